// File: rtl/wbq_pkg.sv
// wbq_pkg: shared widths, entry layout and count-width helper for wb_write_queue.
package wbq_pkg;

   localparam int WBQ_DW    = 32;
   localparam int WBQ_AW    = 5;
   localparam int WBQ_DEPTH = 4;

   typedef struct packed {
      logic [WBQ_AW-1:0] rw;
      logic [WBQ_DW-1:0] data;
   } wbq_entry_t;

   // The count must be able to hold DEPTH itself, so it needs one bit beyond the pointers.
   function automatic int wbq_cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/wbq_fwd_match.sv
// wbq_fwd_match: parallel address compare over pending writes with youngest-first select.
module wbq_fwd_match
   import wbq_pkg::*;
#(
   parameter int N = WBQ_DEPTH + 1
) (
   input  logic [WBQ_AW-1:0]  addr_i,
   input  wbq_entry_t [N-1:0] cand_i,
   input  logic [N-1:0]       valid_i,
   output logic               hit_o,
   output logic [WBQ_DW-1:0]  data_o
);

   // NOTE: every output gets a default first so no path through the block infers a latch.
   always_comb begin
      hit_o  = 1'b0;
      data_o = '0;
      if (addr_i != '0) begin
         // Candidates run oldest (index 0) to youngest, so a later match overrides.
         for (int i = 0; i < N; i++) begin
            if (valid_i[i] && (cand_i[i].rw == addr_i)) begin
               hit_o  = 1'b1;
               data_o = cand_i[i].data;
            end
         end
      end
   end

endmodule

// File: rtl/wb_write_queue.sv
// wb_write_queue: in-order writeback queue retiring one register write per cycle.
// Define WBQ_FWD_EN to add the RA/RB forwarding lookup of pending data.
module wb_write_queue
   import wbq_pkg::*;
#(
   parameter int DEPTH = WBQ_DEPTH,
   parameter int DW    = WBQ_DW,
   parameter int AW    = WBQ_AW
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic          MemWr,
   input  logic [AW-1:0] MemRW,
   input  logic [DW-1:0] MemData,
   input  logic          AluWr,
   input  logic [AW-1:0] AluRW,
   input  logic [DW-1:0] AluData,
`ifdef WBQ_FWD_EN
   input  logic [AW-1:0] RA,
   input  logic [AW-1:0] RB,
   output logic          FwdHitA,
   output logic          FwdHitB,
   output logic [DW-1:0] FwdDataA,
   output logic [DW-1:0] FwdDataB,
`endif
   output logic          Stall,
   output logic          RegWr,
   output logic [AW-1:0] RW,
   output logic [DW-1:0] BusW,
   output logic          Overflow,
   output logic          Empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = wbq_cnt_w(DEPTH);

   // Entries use the package layout, so DW/AW overrides must match wbq_pkg.
   wbq_entry_t    q_mem [DEPTH];
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d, free_s;
   logic          reg_wr_q, overflow_q;
   logic [AW-1:0] rw_q;
   logic [DW-1:0] busw_q;
   logic          deq_s, mem_v, alu_v, take_mem, take_alu, drop_s;

   always_comb begin
      deq_s    = (count_q != '0);
      free_s   = CW'(DEPTH) - count_q + CW'(deq_s);
      mem_v    = MemWr && (MemRW != '0);
      alu_v    = AluWr && (AluRW != '0);
      // Mem is the older instruction: it claims the first free slot, Alu needs one more.
      take_mem = mem_v && (free_s != '0);
      take_alu = alu_v && (free_s > CW'(take_mem));
      drop_s   = (mem_v && !take_mem) || (alu_v && !take_alu);
      head_d   = head_q + PW'(deq_s);
      tail_d   = tail_q + PW'(take_mem) + PW'(take_alu);
      count_d  = count_q + CW'(take_mem) + CW'(take_alu) - CW'(deq_s);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         reg_wr_q   <= 1'b0;
         rw_q       <= '0;
         busw_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         reg_wr_q   <= deq_s;
         overflow_q <= overflow_q | drop_s;
         if (deq_s) begin
            rw_q   <= q_mem[head_q].rw;
            busw_q <= q_mem[head_q].data;
         end
      end
   end

   // NOTE: queue storage has no reset; count_q alone decides which entries are valid.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         if (take_mem) q_mem[tail_q] <= '{rw: MemRW, data: MemData};
         if (take_alu) q_mem[tail_q + PW'(take_mem)] <= '{rw: AluRW, data: AluData};
      end
   end

   assign Stall    = (CW'(DEPTH) - count_q) < CW'(2);
   assign Empty    = (count_q == '0) && !reg_wr_q;
   assign RegWr    = reg_wr_q;
   assign RW       = rw_q;
   assign BusW     = busw_q;
   assign Overflow = overflow_q;

`ifdef WBQ_FWD_EN
   wbq_entry_t [DEPTH:0] cand_s;
   logic [DEPTH:0]       cand_v;

   // Slot 0 is the output stage (oldest); slots 1..DEPTH follow queue order from head.
   always_comb begin
      cand_s[0] = '{rw: rw_q, data: busw_q};
      cand_v[0] = reg_wr_q;
      for (int k = 0; k < DEPTH; k++) begin
         cand_s[k+1] = q_mem[head_q + PW'(k)];
         cand_v[k+1] = (CW'(k) < count_q);
      end
   end

   wbq_fwd_match #(.N(DEPTH + 1)) u_fwd_a (
      .addr_i (RA),
      .cand_i (cand_s),
      .valid_i(cand_v),
      .hit_o  (FwdHitA),
      .data_o (FwdDataA)
   );

   wbq_fwd_match #(.N(DEPTH + 1)) u_fwd_b (
      .addr_i (RB),
      .cand_i (cand_s),
      .valid_i(cand_v),
      .hit_o  (FwdHitB),
      .data_o (FwdDataB)
   );
`endif

endmodule
